// File: rtl/opcode_tag_alloc_pkg.sv
// Shared opcode tag types and default pool geometry for the tag allocator.
package opcode_tag_alloc_pkg;

  localparam int OPCODE_TYPE_W    = 3;
  localparam int OPCODE_NUM_TYPES = 5;
  localparam int TAGS_PER_OPCODE  = 64;
  localparam int OPCODE_SLOT_W    = $clog2(TAGS_PER_OPCODE);
  localparam int OPCODE_TAG_W     = OPCODE_TYPE_W + OPCODE_SLOT_W;

  typedef logic [OPCODE_TAG_W-1:0]  opcodeTagT;
  typedef logic [OPCODE_SLOT_W-1:0] opcodeSlotT;

  typedef enum logic [OPCODE_TYPE_W-1:0] {
    OPCODE_READ  = 3'd0,
    OPCODE_WRITE = 3'd1,
    OPCODE_WAIT  = 3'd2,
    OPCODE_EVICT = 3'd3,
    OPCODE_TRIM  = 3'd4
  } opcodeEnumT;

  typedef struct packed {
    opcodeEnumT otype;
    opcodeSlotT slot;
  } opcodeTagSt;

  // Legacy fixed bases; each pool starts at type * TAGS_PER_OPCODE.
  localparam opcodeTagT OPCODEABASE_READ  = 9'h000;
  localparam opcodeTagT OPCODEABASE_WRITE = 9'h040;
  localparam opcodeTagT OPCODEABASE_WAIT  = 9'h080;
  localparam opcodeTagT OPCODEABASE_EVICT = 9'h0C0;
  localparam opcodeTagT OPCODEABASE_TRIM  = 9'h100;

  function automatic opcodeTagT opcode_base(opcodeEnumT t);
    opcodeTagSt s;
    s.otype = t;
    s.slot  = '0;
    return opcodeTagT'(s);
  endfunction

endpackage

// File: rtl/opcode_tag_alloc_if.sv
// Allocate/response/release handshake bundle between decode and the tag allocator.
interface opcode_tag_alloc_if #(
  parameter int TYPE_W = 3,
  parameter int TAG_W  = 9
);
  logic              alloc_valid;
  logic [TYPE_W-1:0] alloc_type;
  logic              alloc_ready;
  logic              rsp_valid;
  logic [TAG_W-1:0]  rsp_tag;
  logic              rsp_err;
  logic              rel_valid;
  logic [TAG_W-1:0]  rel_tag;
  logic              rel_err;

  modport master (
    output alloc_valid, alloc_type, rel_valid, rel_tag,
    input  alloc_ready, rsp_valid, rsp_tag, rsp_err, rel_err
  );

  modport slave (
    input  alloc_valid, alloc_type, rel_valid, rel_tag,
    output alloc_ready, rsp_valid, rsp_tag, rsp_err, rel_err
  );
endinterface

// File: rtl/opcode_tag_pri_enc.sv
// Lowest-set-bit encoder: o_idx is the index of the least significant 1 in i_vec.
module opcode_tag_pri_enc #(
  parameter  int WIDTH = 64,
  localparam int IDX_W = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] i_vec,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_any
);

  // Scan from the top so the lowest set bit wins last.
  always_comb begin
    o_idx = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      o_idx = i_vec[i] ? IDX_W'(i) : o_idx;
    end
  end

  assign o_any = |i_vec;

endmodule

// File: rtl/opcode_tag_alloc.sv
// Per-opcode-type tag pools: lowest-free-slot allocation, release with error pulse, flush.
// Optional busy-count statistics are built when OPCODE_TAG_ALLOC_STATS_EN is defined.
module opcode_tag_alloc
  import opcode_tag_alloc_pkg::*;
#(
  parameter  int NUM_TYPES     = OPCODE_NUM_TYPES,
  parameter  int TAGS_PER_TYPE = TAGS_PER_OPCODE,
  parameter  int TYPE_W        = OPCODE_TYPE_W,
  localparam int SLOT_W        = $clog2(TAGS_PER_TYPE),
  localparam int TAG_W         = TYPE_W + SLOT_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_flush,
  opcode_tag_alloc_if.slave     bus,
  output logic [NUM_TYPES-1:0]  o_type_full,
  output logic [TAG_W:0]        o_stat_outstanding,
  output logic [TAG_W:0]        o_stat_hwm
);

  localparam logic [TYPE_W:0] NUM_TYPES_L = (TYPE_W + 1)'(NUM_TYPES);

  logic [NUM_TYPES-1:0][TAGS_PER_TYPE-1:0] r_bitmap;
  logic [NUM_TYPES-1:0][TAGS_PER_TYPE-1:0] w_bitmap_nxt;
  logic [NUM_TYPES-1:0]                    r_type_full;

  logic [TAGS_PER_TYPE-1:0] w_sel_pool;
  logic                     w_sel_full;
  logic                     w_type_ok;
  logic                     w_accept;
  logic                     w_acc_ok;
  logic [SLOT_W-1:0]        w_free_idx;
  logic                     w_any_free;
  logic [TAGS_PER_TYPE-1:0] w_acc_mask;

  logic [TYPE_W-1:0]        w_rel_type;
  logic [SLOT_W-1:0]        w_rel_slot;
  logic                     w_rel_type_ok;
  logic                     w_rel_busy;
  logic                     w_rel_ok;
  logic                     w_rel_bad;
  logic [TAGS_PER_TYPE-1:0] w_rel_mask;

  logic                     r_rsp_valid;
  logic [TAG_W-1:0]         r_rsp_tag;
  logic                     r_rsp_err;
  logic                     r_rel_err;

  assign w_type_ok     = {1'b0, bus.alloc_type} < NUM_TYPES_L;
  assign w_rel_type    = bus.rel_tag[TAG_W-1:SLOT_W];
  assign w_rel_slot    = bus.rel_tag[SLOT_W-1:0];
  assign w_rel_type_ok = {1'b0, w_rel_type} < NUM_TYPES_L;

  // Select the requested pool and look up the release target's busy bit.
  always_comb begin
    w_sel_pool = '0;
    w_sel_full = 1'b0;
    w_rel_busy = 1'b0;
    for (int t = 0; t < NUM_TYPES; t++) begin
      w_sel_pool = (bus.alloc_type == TYPE_W'(t)) ? r_bitmap[t]    : w_sel_pool;
      w_sel_full = (bus.alloc_type == TYPE_W'(t)) ? r_type_full[t] : w_sel_full;
      w_rel_busy = (w_rel_type == TYPE_W'(t)) ? r_bitmap[t][w_rel_slot] : w_rel_busy;
    end
  end

  opcode_tag_pri_enc #(
    .WIDTH (TAGS_PER_TYPE)
  ) u_pri_enc (
    .i_vec (~w_sel_pool),
    .o_idx (w_free_idx),
    .o_any (w_any_free)
  );

  // Out-of-range types are always accepted so they can be answered with an error.
  assign bus.alloc_ready = !i_flush && (!w_type_ok || !w_sel_full);
  assign w_accept        = bus.alloc_valid && bus.alloc_ready;
  assign w_acc_ok        = w_accept && w_type_ok && w_any_free;

  assign w_rel_ok  = bus.rel_valid && !i_flush && w_rel_type_ok && w_rel_busy;
  assign w_rel_bad = bus.rel_valid && !i_flush && !(w_rel_type_ok && w_rel_busy);

  assign w_acc_mask = {{(TAGS_PER_TYPE - 1){1'b0}}, 1'b1} << w_free_idx;
  assign w_rel_mask = {{(TAGS_PER_TYPE - 1){1'b0}}, 1'b1} << w_rel_slot;

  // Release and allocate touch different bits, so both apply at one edge.
  always_comb begin
    w_bitmap_nxt = '0;
    for (int t = 0; t < NUM_TYPES; t++) begin
      if (i_flush) begin
        w_bitmap_nxt[t] = '0;
      end else begin
        w_bitmap_nxt[t] =
          (r_bitmap[t] & ~((w_rel_ok && (w_rel_type == TYPE_W'(t))) ? w_rel_mask : '0)) |
          ((w_acc_ok && (bus.alloc_type == TYPE_W'(t))) ? w_acc_mask : '0);
      end
    end
  end

  // Pool bitmaps and their registered full flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bitmap    <= '0;
      r_type_full <= '0;
    end else begin
      r_bitmap <= w_bitmap_nxt;
      for (int t = 0; t < NUM_TYPES; t++) begin
        r_type_full[t] <= &w_bitmap_nxt[t];
      end
    end
  end

  // One-cycle response and release-error pulses; tag/err hold between accepts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp_valid <= 1'b0;
      r_rsp_tag   <= '0;
      r_rsp_err   <= 1'b0;
      r_rel_err   <= 1'b0;
    end else begin
      r_rsp_valid <= w_accept;
      r_rel_err   <= w_rel_bad;
      if (w_accept) begin
        r_rsp_tag <= w_acc_ok ? {bus.alloc_type, w_free_idx} : '0;
        r_rsp_err <= !w_type_ok;
      end
    end
  end

  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_tag   = r_rsp_tag;
  assign bus.rsp_err   = r_rsp_err;
  assign bus.rel_err   = r_rel_err;
  assign o_type_full   = r_type_full;

`ifdef OPCODE_TAG_ALLOC_STATS_EN
  logic [TAG_W:0] r_outstanding;
  logic [TAG_W:0] r_hwm;
  logic [TAG_W:0] w_out_nxt;

  // Net busy count for this edge; flush wins over everything.
  always_comb begin
    w_out_nxt = r_outstanding;
    if (i_flush) begin
      w_out_nxt = '0;
    end else begin
      w_out_nxt = r_outstanding + (TAG_W + 1)'(w_acc_ok) - (TAG_W + 1)'(w_rel_ok);
    end
  end

  // Busy counter and its high-water mark; the mark survives flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_outstanding <= '0;
      r_hwm         <= '0;
    end else begin
      r_outstanding <= w_out_nxt;
      if (w_out_nxt > r_hwm) begin
        r_hwm <= w_out_nxt;
      end
    end
  end

  assign o_stat_outstanding = r_outstanding;
  assign o_stat_hwm         = r_hwm;
`else
  assign o_stat_outstanding = '0;
  assign o_stat_hwm         = '0;
`endif

endmodule

// File: tb/tb_opcode_tag_alloc.sv
// Directed plus randomized bench for opcode_tag_alloc against a pool/slot reference model.
module tb_opcode_tag_alloc;
  localparam int NT  = 5;
  localparam int TPT = 64;
  localparam int TW  = 3;
  localparam int GW  = 9;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic          flush = 1'b0;
  logic [NT-1:0] type_full;
  logic [GW:0]   stat_out;
  logic [GW:0]   stat_hwm;

  opcode_tag_alloc_if #(.TYPE_W(TW), .TAG_W(GW)) bus ();

  opcode_tag_alloc #(
    .NUM_TYPES     (NT),
    .TAGS_PER_TYPE (TPT),
    .TYPE_W        (TW)
  ) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .i_flush            (flush),
    .bus                (bus),
    .o_type_full        (type_full),
    .o_stat_outstanding (stat_out),
    .o_stat_hwm         (stat_hwm)
  );

  always #5 clk = ~clk;

  bit          busy [NT][TPT];
  int          m_out, m_hwm;
  logic [GW-1:0] m_tag;
  logic        m_err;
  int          tests = 0;
  int          fails = 0;

  task automatic check(string name, logic [31:0] obs, logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  function automatic int pool_cnt(int t);
    int n = 0;
    for (int s = 0; s < TPT; s++) n += busy[t][s] ? 1 : 0;
    return n;
  endfunction

  function automatic int total_busy();
    int n = 0;
    for (int t = 0; t < NT; t++) n += pool_cnt(t);
    return n;
  endfunction

  function automatic int lowest_free(int t);
    for (int s = 0; s < TPT; s++) if (!busy[t][s]) return s;
    return -1;
  endfunction

  task automatic model_reset();
    for (int t = 0; t < NT; t++) for (int s = 0; s < TPT; s++) busy[t][s] = 1'b0;
    m_out = 0; m_hwm = 0; m_tag = '0; m_err = 1'b0;
  endtask

  // One clock: drive at posedge+1, check ready at +2, check outputs at next posedge+1.
  task automatic cycle(bit av, int at, bit rv, int rt, bit fl);
    bit rdy, acc, rerr;
    int slot, rtype, rslot;
    logic [NT-1:0] f;
    bus.alloc_valid = av;
    bus.alloc_type  = at[TW-1:0];
    bus.rel_valid   = rv;
    bus.rel_tag     = rt[GW-1:0];
    flush           = fl;
    #1;
    rdy = !fl && (at >= NT || pool_cnt(at) < TPT);
    check("alloc_ready", bus.alloc_ready, rdy);
    acc  = av && rdy;
    slot = -1;
    if (acc) begin
      if (at < NT) begin
        slot  = lowest_free(at);
        m_tag = GW'(at * TPT + slot);
        m_err = 1'b0;
      end else begin
        m_tag = '0;
        m_err = 1'b1;
      end
    end
    rtype = rt / TPT;
    rslot = rt % TPT;
    rerr  = 1'b0;
    if (fl) begin
      for (int t = 0; t < NT; t++) for (int s = 0; s < TPT; s++) busy[t][s] = 1'b0;
    end else begin
      if (rv) begin
        if (rtype >= NT) rerr = 1'b1;
        else if (!busy[rtype][rslot]) rerr = 1'b1;
        else busy[rtype][rslot] = 1'b0;
      end
      if (acc && at < NT) busy[at][slot] = 1'b1;
    end
    m_out = total_busy();
    if (m_out > m_hwm) m_hwm = m_out;
    for (int t = 0; t < NT; t++) f[t] = (pool_cnt(t) == TPT);
    @(posedge clk);
    #1;
    check("rsp_valid", bus.rsp_valid, acc);
    check("rsp_tag", bus.rsp_tag, m_tag);
    check("rsp_err", bus.rsp_err, m_err);
    check("rel_err", bus.rel_err, rerr);
    check("type_full", type_full, f);
`ifdef OPCODE_TAG_ALLOC_STATS_EN
    check("stat_outstanding", stat_out, m_out);
    check("stat_hwm", stat_hwm, m_hwm);
`else
    check("stat_outstanding_tied", stat_out, 0);
    check("stat_hwm_tied", stat_hwm, 0);
`endif
  endtask

  initial begin
    int rt, t0, s0;
    bus.alloc_valid = 1'b0;
    bus.alloc_type  = '0;
    bus.rel_valid   = 1'b0;
    bus.rel_tag     = '0;
    model_reset();

    // Reset state
    @(posedge clk); @(posedge clk); #1;
    check("reset_rsp_valid", bus.rsp_valid, 0);
    check("reset_rsp_tag", bus.rsp_tag, 0);
    check("reset_rsp_err", bus.rsp_err, 0);
    check("reset_rel_err", bus.rel_err, 0);
    check("reset_type_full", type_full, 0);
    check("reset_stat_out", stat_out, 0);
    check("reset_stat_hwm", stat_hwm, 0);
    rst_n = 1'b1;

    // Two allocations of WRITE
    cycle(1, 1, 0, 0, 0);
    check("write_first_tag", bus.rsp_tag, 9'h040);
    cycle(1, 1, 0, 0, 0);
    check("write_second_tag", bus.rsp_tag, 9'h041);

    // Fill TRIM pool
    for (int i = 0; i < TPT; i++) cycle(1, 4, 0, 0, 0);
    check("trim_last_tag", bus.rsp_tag, 9'h13F);
    check("trim_full", type_full[4], 1'b1);
    cycle(1, 4, 0, 0, 0);
    bus.alloc_type = 3'd0;
    #1;
    check("type0_ready", bus.alloc_ready, 1'b1);

    // Release into a full pool does not raise ready that cycle
    cycle(1, 4, 1, 'h105, 0);
    cycle(1, 4, 0, 0, 0);
    check("reissue_0x105", bus.rsp_tag, 9'h105);

    // Bad type and bad releases
    cycle(1, 6, 0, 0, 0);
    check("badtype_err", bus.rsp_err, 1'b1);
    check("badtype_tag", bus.rsp_tag, 9'h000);
    cycle(0, 0, 1, 'h1C0, 0);
    check("bad_rel_type", bus.rel_err, 1'b1);
    cycle(0, 0, 1, 'h041, 0);
    check("good_rel", bus.rel_err, 1'b0);
    cycle(0, 0, 1, 'h041, 0);
    check("double_rel", bus.rel_err, 1'b1);

    // Asynchronous reset with a response pending
    cycle(1, 2, 0, 0, 0);
    rst_n = 1'b0;
    #1;
    check("arst_rsp_valid", bus.rsp_valid, 0);
    check("arst_rsp_tag", bus.rsp_tag, 0);
    check("arst_type_full", type_full, 0);
    check("arst_stat_out", stat_out, 0);
    model_reset();
    bus.alloc_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    cycle(1, 3, 0, 0, 0);
    check("post_reset_slot0", bus.rsp_tag, 9'h0C0);

    // Ten outstanding then flush (release during flush is ignored)
    for (int i = 0; i < 9; i++) cycle(1, $urandom_range(0, NT - 1), 0, 0, 0);
    cycle(1, 0, 1, 'h0C0, 1);
    check("flush_type_full", type_full, 0);
    check("flush_no_rel_err", bus.rel_err, 0);
`ifdef OPCODE_TAG_ALLOC_STATS_EN
    check("flush_stat_out", stat_out, 0);
    check("flush_stat_hwm", stat_hwm, 10);
`endif
    cycle(1, 0, 0, 0, 0);
    check("post_flush_tag", bus.rsp_tag, 9'h000);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      rt = $urandom_range(0, 511);
      if ($urandom_range(0, 1) == 1) begin
        t0 = $urandom_range(0, NT - 1);
        s0 = lowest_free(t0);
        for (int s = 0; s < TPT; s++) if (busy[t0][s]) rt = t0 * TPT + s;
        if (s0 > 0) rt = t0 * TPT + s0 - 1;
      end
      cycle($urandom_range(0, 3) != 0, $urandom_range(0, 7),
            $urandom_range(0, 2) == 0, rt, $urandom_range(0, 79) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
